spi_tx_arbiter: RTL and testbench



---
 rtl/spi_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_tx_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI transmitter between P_NUM_REQ word sources.
// Round-robin arbitration in IDLE. A non-last word locks the transmitter to
// its owner until that owner sends a word with req_last set. Define
// SPI_ARB_WDOG_EN to build a watchdog that releases a stalled lock after
// P_LOCK_TIMEOUT idle cycles and pulses lock_abort.
module spi_tx_arbiter #(
  parameter int P_DATA_WIDTH   = 8,
  parameter int P_NUM_REQ      = 4,
  parameter int P_LOCK_TIMEOUT = 255
) (
  input  logic                                clk_100,
  input  logic                                s_rst,
  input  logic [P_NUM_REQ-1:0]                req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0]   req_data,
  input  logic [P_NUM_REQ-1:0]                req_last,
  output logic [P_NUM_REQ-1:0]                req_ready,
  output logic                                tx_valid,
  output logic [P_DATA_WIDTH-1:0]             tx_data,
  input  logic                                tx_ready,
  output logic [$clog2(P_NUM_REQ)-1:0]        grant_id,
  output logic                                busy,
  output logic                                lock_abort
);

  localparam int IW = $clog2(P_NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  state_t                  state_r;
  logic [IW-1:0]           rr_ptr_r;
  logic                    last_r;
  logic [IW-1:0]           sel_s;
  logic                    sel_found_s;
  logic [IW-1:0]           acc_idx_s;
  logic                    accept_s;
  logic [P_DATA_WIDTH-1:0] acc_word_s;
  logic                    acc_last_s;

`ifdef SPI_ARB_WDOG_EN
  localparam int WW = $clog2(P_LOCK_TIMEOUT + 1);
  logic [WW-1:0]           wdog_cnt_r;
`endif

  // Round-robin search: first valid requester after rr_ptr, wrapping around.
  // Iterating from the farthest slot down lets the nearest one win.
  always_comb begin
    sel_s       = {IW{1'b0}};
    sel_found_s = 1'b0;
    for (int k = P_NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr_r) + k) % P_NUM_REQ]) begin
        sel_s       = IW'((int'(rr_ptr_r) + k) % P_NUM_REQ);
        sel_found_s = 1'b1;
      end else begin
        sel_s       = sel_s;
        sel_found_s = sel_found_s;
      end
    end
  end

  // Accept strobe: arbitration winner in IDLE, only the owner in LOCK, none in SEND.
  always_comb begin
    req_ready = {P_NUM_REQ{1'b0}};
    acc_idx_s = grant_id;
    case (state_r)
      ST_IDLE: begin
        acc_idx_s = sel_s;
        if (sel_found_s) begin
          req_ready[sel_s] = 1'b1;
        end else begin
          req_ready = {P_NUM_REQ{1'b0}};
        end
      end
      ST_LOCK: begin
        req_ready[grant_id] = req_valid[grant_id];
      end
      default: begin
        req_ready = {P_NUM_REQ{1'b0}};
      end
    endcase
  end

  // Word and last flag of whichever requester is being accepted this cycle.
  always_comb begin
    accept_s   = |req_ready;
    acc_word_s = req_data[int'(acc_idx_s) * P_DATA_WIDTH +: P_DATA_WIDTH];
    acc_last_s = req_last[acc_idx_s];
  end

  // Arbiter FSM with registered transmitter handshake and status outputs.
  always_ff @(posedge clk_100) begin
    if (s_rst) begin
      state_r    <= ST_IDLE;
      rr_ptr_r   <= IW'(P_NUM_REQ - 1);
      last_r     <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= {P_DATA_WIDTH{1'b0}};
      grant_id   <= {IW{1'b0}};
      busy       <= 1'b0;
`ifdef SPI_ARB_WDOG_EN
      lock_abort <= 1'b0;
      wdog_cnt_r <= {WW{1'b0}};
`endif
    end else begin
`ifdef SPI_ARB_WDOG_EN
      lock_abort <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_data  <= acc_word_s;
            last_r   <= acc_last_s;
            grant_id <= sel_s;
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (last_r) begin
              rr_ptr_r <= grant_id;
              busy     <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              state_r  <= ST_LOCK;
            end
`ifdef SPI_ARB_WDOG_EN
            wdog_cnt_r <= {WW{1'b0}};
`endif
          end
        end
        ST_LOCK: begin
          if (accept_s) begin
            tx_data  <= acc_word_s;
            last_r   <= acc_last_s;
            tx_valid <= 1'b1;
            state_r  <= ST_SEND;
`ifdef SPI_ARB_WDOG_EN
            wdog_cnt_r <= {WW{1'b0}};
          end else if (wdog_cnt_r == WW'(P_LOCK_TIMEOUT - 1)) begin
            // Owner stalled too long: drop the lock and demote the owner.
            lock_abort <= 1'b1;
            rr_ptr_r   <= grant_id;
            busy       <= 1'b0;
            state_r    <= ST_IDLE;
            wdog_cnt_r <= {WW{1'b0}};
          end else begin
            wdog_cnt_r <= wdog_cnt_r + WW'(1);
`endif
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifndef SPI_ARB_WDOG_EN
  assign lock_abort = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Self-checking bench for spi_tx_arbiter (4 requesters, 8-bit words).
// Expected transmitter words are queued as stimulus is driven and popped by
// a monitor on every tx handshake.
module tb_spi_tx_arbiter;

  logic        clk_100;
  logic        s_rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic        lock_abort;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_tx_arbiter #(
    .P_DATA_WIDTH  (8),
    .P_NUM_REQ     (4),
    .P_LOCK_TIMEOUT(16)
  ) dut (
    .clk_100   (clk_100),
    .s_rst     (s_rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .lock_abort(lock_abort)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #2;
  endtask

  task automatic wait_ready(input logic [3:0] exp, input string tag);
    int n;
    n = 0;
    while (req_ready == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    check(tag, {28'd0, req_ready}, {28'd0, exp});
  endtask

  // Scoreboard: every transmitter handshake must deliver the next queued word.
  always @(negedge clk_100) begin
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected_word", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("tx_word", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    s_rst     = 1'b1;
    req_valid = 4'b0000;
    req_data  = 32'h0000_0000;
    req_last  = 4'b0000;
    tx_ready  = 1'b0;

    // Reset then idle
    step();
    step();
    s_rst = 1'b0;
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_lock_abort", {31'd0, lock_abort}, 32'd0);

    // Simultaneous single words: round-robin 0,1,2,3
    req_data  = 32'hA3A2_A1A0;
    req_last  = 4'b1111;
    tx_ready  = 1'b1;
    req_valid = 4'b1111;
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3);
    #1;
    for (int w = 0; w < 4; w++) begin
      wait_ready(4'(1 << w), "rr_onehot");
      step();
      req_valid[w] = 1'b0;
      #1;
      check("rr_send_valid", {31'd0, tx_valid}, 32'd1);
      check("rr_send_noready", {28'd0, req_ready}, 32'd0);
      check("rr_grant", {30'd0, grant_id}, w);
      step();
    end
    check("rr_tx_valid_drop", {31'd0, tx_valid}, 32'd0);
    check("rr_busy_drop", {31'd0, busy}, 32'd0);

    // Burst lock: requester 2 sends 3 words while requester 1 waits
    req_data  = 32'h00C1_B000 | 32'h0000_00B0 << 16;
    req_data[23:16] = 8'hB0;
    req_data[15:8]  = 8'hC1;
    req_last  = 4'b0010;
    req_valid = 4'b0100;
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC1);
    #1;
    wait_ready(4'b0100, "burst_first_grant");
    step();
    req_valid[1]    = 1'b1;
    req_data[23:16] = 8'hB1;
    #1;
    check("burst_send_noready", {28'd0, req_ready}, 32'd0);
    check("burst_grant_w0", {30'd0, grant_id}, 32'd2);
    step();
    check("burst_lock_owner_only", {28'd0, req_ready}, 32'h4);
    check("burst_lock_busy", {31'd0, busy}, 32'd1);
    step();
    req_data[23:16] = 8'hB2;
    req_last[2]     = 1'b1;
    #1;
    step();
    check("burst_lock_owner_only2", {28'd0, req_ready}, 32'h4);
    step();
    req_valid[2] = 1'b0;
    #1;
    check("burst_grant_w2", {30'd0, grant_id}, 32'd2);
    step();
    check("burst_then_req1", {28'd0, req_ready}, 32'h2);
    step();
    req_valid[1] = 1'b0;
    step();

    // Transmitter backpressure with requester 0 also waiting
    tx_ready        = 1'b0;
    req_data[31:24] = 8'h5C;
    req_data[7:0]   = 8'hD0;
    req_last        = 4'b1001;
    req_valid       = 4'b1001;
    exp_q.push_back(8'h5C);
    exp_q.push_back(8'hD0);
    #1;
    wait_ready(4'b1000, "bp_grant3");
    step();
    req_valid[3] = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      check("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
      check("bp_tx_data", {24'd0, tx_data}, 32'h5C);
      check("bp_no_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    tx_ready = 1'b1;
    step();
    check("bp_valid_after_hs", {31'd0, tx_valid}, 32'd0);
    check("bp_next_req0", {28'd0, req_ready}, 32'h1);
    step();
    req_valid[0] = 1'b0;
    step();

    // Reset mid-transfer: in-flight word is discarded
    tx_ready        = 1'b0;
    req_data[15:8]  = 8'hE1;
    req_last        = 4'b1111;
    req_valid       = 4'b0010;
    #1;
    wait_ready(4'b0010, "mr_grant1");
    step();
    req_valid = 4'b0000;
    #1;
    check("mr_in_send", {31'd0, tx_valid}, 32'd1);
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    #1;
    check("mr_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_grant_id", {30'd0, grant_id}, 32'd0);
    check("mr_tx_data", {24'd0, tx_data}, 32'd0);
    tx_ready       = 1'b1;
    req_data[7:0]  = 8'hF0;
    req_data[15:8] = 8'hF1;
    req_valid      = 4'b0011;
    exp_q.push_back(8'hF0);
    #1;
    check("mr_req0_first", {28'd0, req_ready}, 32'h1);
    step();
    req_valid = 4'b0000;
    step();

    // Stalled lock: owner 2 sends a non-last word then idles, requester 3 waits
    req_data[23:16] = 8'h60;
    req_data[31:24] = 8'h73;
    req_last        = 4'b1000;
    req_valid       = 4'b1100;
    exp_q.push_back(8'h60);
    #1;
    wait_ready(4'b0100, "wd_grant2");
    step();
    req_valid[2] = 1'b0;
    step();
`ifdef SPI_ARB_WDOG_EN
    for (int c = 0; c < 16; c++) begin
      check("wd_no_abort_yet", {31'd0, lock_abort}, 32'd0);
      check("wd_lock_hold", {28'd0, req_ready}, 32'd0);
      step();
    end
    check("wd_abort_pulse", {31'd0, lock_abort}, 32'd1);
    check("wd_busy_clear", {31'd0, busy}, 32'd0);
    check("wd_other_granted", {28'd0, req_ready}, 32'h8);
    exp_q.push_back(8'h73);
    step();
    req_valid[3] = 1'b0;
    #1;
    check("wd_abort_one_cycle", {31'd0, lock_abort}, 32'd0);
    step();
`else
    for (int c = 0; c < 20; c++) begin
      check("lk_no_abort", {31'd0, lock_abort}, 32'd0);
      check("lk_lock_hold", {28'd0, req_ready}, 32'd0);
      check("lk_busy", {31'd0, busy}, 32'd1);
      step();
    end
    req_data[23:16] = 8'h61;
    req_last[2]     = 1'b1;
    req_valid[2]    = 1'b1;
    exp_q.push_back(8'h61);
    #1;
    check("lk_owner_resumes", {28'd0, req_ready}, 32'h4);
    step();
    req_valid[2] = 1'b0;
    step();
    exp_q.push_back(8'h73);
    check("lk_then_req3", {28'd0, req_ready}, 32'h8);
    step();
    req_valid[3] = 1'b0;
    step();
`endif

    step();
    step();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
